uart_rx_pkt_ctrl: RTL and testbench

UART_RX_PKT_CTRL -- requirements
Module: uart_rx_pkt_ctrl

---
 rtl/uart_rx_pkt_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind a UART receiver: SOF, LEN, payload, optional CSUM, then drains the payload.
// Define UART_PKT_CSUM_EN to expect and verify a trailing checksum byte.
module uart_rx_pkt_ctrl #(
   parameter logic [7:0]  SOF          = 8'hA5,
   parameter int unsigned MAX_LEN      = 16,
   parameter int unsigned TIMEOUT_CLKS = 60000,
   parameter int unsigned RECOVER_CLKS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_done,
   input  logic [7:0] rx_data,
   input  logic       rx_error,
   output logic       rx_clr,
   output logic       busy,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_last,
   output logic       pkt_ok,
   output logic       pkt_err,
   output logic [2:0] err_code
);

   localparam int unsigned LW = $clog2(MAX_LEN + 1);
   localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
   localparam int unsigned RW = $clog2(RECOVER_CLKS + 1);
   localparam logic [8:0]    MAX_LEN_B = 9'(MAX_LEN);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
   localparam logic [RW-1:0] REC_LAST  = RW'(RECOVER_CLKS - 1);
   localparam logic [LW-1:0] ONE       = LW'(1);

   typedef enum logic [2:0] {
      S_HUNT, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN, S_RECOVER
   } state_e;

   state_e        state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [LW-1:0] idx_q, idx_d;
   logic [LW-1:0] rd_q, rd_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [RW-1:0] rec_q, rec_d;
   logic          ok_q, ok_d;
   logic          err_q, err_d;
   logic [2:0]    code_q, code_d;
   logic          wr_en;
   logic [7:0]    buf_q [MAX_LEN];
`ifdef UART_PKT_CSUM_EN
   logic [7:0]    sum_q, sum_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q  <= '0;
         idx_q  <= '0;
         rd_q   <= '0;
         tmo_q  <= '0;
         rec_q  <= '0;
         ok_q   <= 1'b0;
         err_q  <= 1'b0;
         code_q <= '0;
`ifdef UART_PKT_CSUM_EN
         sum_q  <= '0;
`endif
      end else begin
         len_q  <= len_d;
         idx_q  <= idx_d;
         rd_q   <= rd_d;
         tmo_q  <= tmo_d;
         rec_q  <= rec_d;
         ok_q   <= ok_d;
         err_q  <= err_d;
         code_q <= code_d;
`ifdef UART_PKT_CSUM_EN
         sum_q  <= sum_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         buf_q[idx_q[IW-1:0]] <= rx_data;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      rd_d    = rd_q;
      tmo_d   = '0;
      rec_d   = rec_q;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      code_d  = code_q;
      wr_en   = 1'b0;
`ifdef UART_PKT_CSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         S_HUNT: begin
            if (rx_error) begin
               err_d   = 1'b1;
               code_d  = 3'b011;
               rec_d   = '0;
               state_d = S_RECOVER;
            end else if (rx_done && rx_data == SOF) begin
               state_d = S_LEN;
            end
         end
         S_LEN, S_PAYLOAD, S_CSUM: begin
            // rx_error outranks a same-cycle byte; the timeout can only fire on byte-free cycles
            if (rx_error) begin
               err_d   = 1'b1;
               code_d  = 3'b011;
               rec_d   = '0;
               state_d = S_RECOVER;
            end else if (rx_done) begin
               if (state_q == S_LEN) begin
                  if (rx_data == 8'h00 || {1'b0, rx_data} > MAX_LEN_B) begin
                     err_d   = 1'b1;
                     code_d  = 3'b000;
                     state_d = S_HUNT;
                  end else begin
                     len_d   = LW'(rx_data);
                     idx_d   = '0;
`ifdef UART_PKT_CSUM_EN
                     sum_d   = rx_data;
`endif
                     state_d = S_PAYLOAD;
                  end
               end else if (state_q == S_PAYLOAD) begin
                  wr_en = 1'b1;
                  idx_d = idx_q + ONE;
`ifdef UART_PKT_CSUM_EN
                  sum_d = sum_q + rx_data;
                  if (idx_q == len_q - ONE) begin
                     state_d = S_CSUM;
                  end
`else
                  if (idx_q == len_q - ONE) begin
                     ok_d    = 1'b1;
                     rd_d    = '0;
                     state_d = S_DRAIN;
                  end
`endif
               end else begin
`ifdef UART_PKT_CSUM_EN
                  if (sum_q + rx_data == 8'h00) begin
                     ok_d    = 1'b1;
                     rd_d    = '0;
                     state_d = S_DRAIN;
                  end else begin
                     err_d   = 1'b1;
                     code_d  = 3'b001;
                     state_d = S_HUNT;
                  end
`else
                  state_d = S_HUNT;
`endif
               end
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               code_d  = 3'b010;
               state_d = S_HUNT;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (out_ready) begin
               if (rd_q == len_q - ONE) begin
                  if (rx_error) begin
                     err_d   = 1'b1;
                     code_d  = 3'b011;
                     rec_d   = '0;
                     state_d = S_RECOVER;
                  end else begin
                     state_d = S_HUNT;
                  end
               end else begin
                  rd_d = rd_q + ONE;
               end
            end
            // a byte landing mid-drain is dropped; the exit rx_error report wins the same cycle
            if (rx_done && !err_d) begin
               err_d  = 1'b1;
               code_d = 3'b100;
            end
         end
         S_RECOVER: begin
            if (rec_q == REC_LAST) begin
               state_d = S_HUNT;
            end else begin
               rec_d = rec_q + 1'b1;
            end
         end
         default: state_d = S_HUNT;
      endcase
   end

   always_comb begin
      busy      = (state_q != S_HUNT);
      out_valid = (state_q == S_DRAIN);
      rx_clr    = (state_q == S_RECOVER);
      out_data  = '0;
      out_last  = 1'b0;
      if (state_q == S_DRAIN) begin
         out_data = buf_q[rd_q[IW-1:0]];
         out_last = (rd_q == len_q - ONE);
      end
   end

   assign pkt_ok   = ok_q;
   assign pkt_err  = err_q;
   assign err_code = code_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Self-checking bench for uart_rx_pkt_ctrl; follows UART_PKT_CSUM_EN to decide whether a checksum byte is sent.
module tb_uart_rx_pkt_ctrl;

   localparam int unsigned T    = 64;
   localparam int unsigned MAXL = 16;
   localparam int unsigned REC  = 4;
   localparam logic [7:0]  SOF  = 8'hA5;
`ifdef UART_PKT_CSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic       clk = 1'b0, rst = 1'b1;
   logic       rx_done = 1'b0, rx_error = 1'b0, out_ready = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_clr, busy, out_valid, out_last, pkt_ok, pkt_err;
   logic [7:0] out_data;
   logic [2:0] err_code;

   uart_rx_pkt_ctrl #(
      .SOF(SOF), .MAX_LEN(MAXL), .TIMEOUT_CLKS(T), .RECOVER_CLKS(REC)
   ) dut (
      .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data), .rx_error(rx_error),
      .rx_clr(rx_clr), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
      .err_code(err_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] b;
      int unsigned nb;
      int unsigned ok;
      int          err;
      int unsigned nout;
      logic [23:0] o;
   } vec_t;

   int unsigned n_cmp = 0, n_bad = 0;
   int unsigned ready_mode = 0;
   int unsigned ok_cnt = 0, exp_ok = 0;
   logic [2:0]  err_q[$], exp_err[$];
   logic [8:0]  out_q[$], exp_out[$];
   vec_t        tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic wait_idle(input string name);
      int unsigned k = 0;
      while (busy && k < 2000) begin
         tick();
         k++;
      end
      chk({name, "_idle"}, 32'(busy), 32'd0);
      tick();
      tick();
   endtask

   task automatic clear_all();
      ok_cnt = 0;
      exp_ok = 0;
      err_q.delete();
      exp_err.delete();
      out_q.delete();
      exp_out.delete();
   endtask

   task automatic compare_mon(input string name);
      chk({name, "_okcnt"}, 32'(ok_cnt), 32'(exp_ok));
      chk({name, "_nerr"}, 32'(err_q.size()), 32'(exp_err.size()));
      for (int i = 0; i < exp_err.size(); i++)
         if (i < err_q.size()) chk({name, "_errcode"}, 32'(err_q[i]), 32'(exp_err[i]));
      chk({name, "_nout"}, 32'(out_q.size()), 32'(exp_out.size()));
      for (int i = 0; i < exp_out.size(); i++)
         if (i < out_q.size()) chk({name, "_out"}, 32'(out_q[i]), 32'(exp_out[i]));
   endtask

   task automatic add_vec(input logic [63:0] b, input int unsigned nb, input int unsigned ok,
                          input int err, input int unsigned nout, input logic [23:0] o);
      vec_t v;
      v.b = b; v.nb = nb; v.ok = ok; v.err = err; v.nout = nout; v.o = o;
      tbl.push_back(v);
   endtask

   task automatic apply_vec(input vec_t v, input string name);
      clear_all();
      exp_ok = v.ok;
      if (v.err >= 0) exp_err.push_back(3'(v.err));
      for (int i = 0; i < int'(v.nout); i++)
         exp_out.push_back({i == int'(v.nout) - 1, v.o[23-8*i -: 8]});
      for (int i = 0; i < int'(v.nb); i++) send_byte(v.b[63-8*i -: 8], 1);
      wait_idle(name);
      compare_mon(name);
   endtask

   // out_ready driver
   initial forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   // output monitor: collects pulses/handshakes and checks stall stability
   logic       prev_stall = 1'b0;
   logic [8:0] prev_o = '0;
   initial forever begin
      @(negedge clk);
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (pkt_ok || pkt_err) chk("ok_err_excl", 32'(pkt_ok & pkt_err), 32'd0);
         if (pkt_ok) ok_cnt++;
         if (pkt_err) err_q.push_back(err_code);
         if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'({out_last, out_data}), 32'(prev_o));
         end
         if (out_valid && out_ready) out_q.push_back({out_last, out_data});
         prev_stall = out_valid && !out_ready;
         prev_o     = {out_last, out_data};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  pl [MAXL];
      logic [7:0]  s, c, g;
      int unsigned len, kind, hi, k;

`ifdef UART_PKT_CSUM_EN
      add_vec(64'h00FF_A503_1122_3397, 8, 1, -1, 3, 24'h112233);
      add_vec(64'hA503_1122_3396_0000, 6, 0,  1, 0, 24'h000000);
      add_vec(64'hA500_0000_0000_0000, 2, 0,  0, 0, 24'h000000);
      add_vec(64'hA511_0000_0000_0000, 2, 0,  0, 0, 24'h000000);
      add_vec(64'h5AA5_015A_A500_0000, 5, 1, -1, 1, 24'h5A0000);
      add_vec(64'hA501_00FF_0000_0000, 4, 1, -1, 1, 24'h000000);
`else
      add_vec(64'h00FF_A503_1122_3300, 7, 1, -1, 3, 24'h112233);
      add_vec(64'hA500_0000_0000_0000, 2, 0,  0, 0, 24'h000000);
      add_vec(64'hA511_0000_0000_0000, 2, 0,  0, 0, 24'h000000);
      add_vec(64'h5AA5_015A_0000_0000, 4, 1, -1, 1, 24'h5A0000);
      add_vec(64'hA502_A500_0000_0000, 4, 1, -1, 2, 24'hA50000);
      add_vec(64'hA501_FF00_0000_0000, 3, 1, -1, 1, 24'hFF0000);
`endif

      // reset values
      repeat (3) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_ok", 32'(pkt_ok), 32'd0);
      chk("rst_err", 32'(pkt_err), 32'd0);
      chk("rst_clr", 32'(rx_clr), 32'd0);
      chk("rst_code", 32'(err_code), 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

      // inter-byte timeout, then a clean packet
      clear_all();
      send_byte(SOF, 1);
      send_byte(8'h02, 1);
      send_byte(8'h44, 0);
      k = 0;
      while (!pkt_err && k < T + 10) begin
         tick();
         k++;
      end
      chk("tmo_cycles", 32'(k), 32'(T));
      tick();
      exp_err.push_back(3'b010);
      compare_mon("tmo");
      apply_vec(tbl[CSUM_EN ? 4 : 3], "after_tmo");

      // rx_error mid-payload -> RECOVER with rx_clr for REC cycles
      clear_all();
      send_byte(SOF, 1);
      send_byte(8'h03, 1);
      send_byte(8'h11, 1);
      send_byte(8'h22, 0);
      rx_error = 1'b1;
      tick();
      rx_error = 1'b0;
      chk("rec_busy", 32'(busy), 32'd1);
      hi = 0;
      for (int i = 0; i < 12; i++) begin
         if (rx_clr) hi++;
         tick();
      end
      chk("rec_clr_cycles", 32'(hi), 32'(REC));
      chk("rec_busy_end", 32'(busy), 32'd0);
      exp_err.push_back(3'b011);
      compare_mon("rx_error");

      // stalled drain with a stray byte
      clear_all();
      ready_mode = 2;
      tick();
      tick();
      send_byte(SOF, 1);
      send_byte(8'h02, 1);
      send_byte(8'h10, 1);
      if (CSUM_EN) begin
         send_byte(8'h20, 1);
         send_byte(8'hCE, 2);
      end else begin
         send_byte(8'h20, 2);
      end
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'h10);
      send_byte(8'h77, 1);
      chk("stall_data_held", 32'(out_data), 32'h10);
      ready_mode = 0;
      wait_idle("stall");
      exp_ok = 1;
      exp_err.push_back(3'b100);
      exp_out.push_back(9'h010);
      exp_out.push_back(9'h120);
      compare_mon("stall");

      // reset mid-packet and mid-drain
      clear_all();
      send_byte(SOF, 1);
      send_byte(8'h03, 1);
      send_byte(8'h11, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstpkt_busy", 32'(busy), 32'd0);
      repeat (T + 5) tick();
      compare_mon("rst_mid_pkt");
      clear_all();
      ready_mode = 2;
      tick();
      tick();
      send_byte(SOF, 1);
      send_byte(8'h01, 1);
      if (CSUM_EN) begin
         send_byte(8'h5A, 1);
         send_byte(8'hA5, 2);
      end else begin
         send_byte(8'h5A, 2);
      end
      chk("rstdrn_valid_pre", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstdrn_valid", 32'(out_valid), 32'd0);
      chk("rstdrn_data", 32'(out_data), 32'd0);
      tick();
      rst = 1'b0;
      ready_mode = 0;
      repeat (4) tick();
      exp_ok = 1;
      compare_mon("rst_mid_drain");

      // randomized packets against a frame-level model
      clear_all();
      ready_mode = 1;
      for (int it = 0; it < 40; it++) begin
         for (int n = 0; n < int'($urandom_range(0, 2)); n++) begin
            g = 8'($urandom);
            if (g == SOF) g = 8'h00;
            send_byte(g, $urandom_range(0, 3));
         end
         kind = (it < 2) ? 0 : $urandom_range(0, 7);
         send_byte(SOF, $urandom_range(0, 3));
         if (kind == 6) begin
            len = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAXL + 1, 255);
            send_byte(8'(len), $urandom_range(0, 3));
            exp_err.push_back(3'b000);
         end else begin
            len = (it == 0) ? 1 : (it == 1) ? MAXL : $urandom_range(1, MAXL);
            send_byte(8'(len), $urandom_range(0, 3));
            s = 8'(len);
            for (int i = 0; i < int'(len); i++) begin
               pl[i] = 8'($urandom);
               s = s + pl[i];
               send_byte(pl[i], $urandom_range(0, 3));
            end
            c = 8'h00 - s;
            if (CSUM_EN && kind == 7) begin
               c = c + 8'($urandom_range(1, 255));
               exp_err.push_back(3'b001);
            end else begin
               exp_ok++;
               for (int i = 0; i < int'(len); i++) exp_out.push_back({i == int'(len) - 1, pl[i]});
            end
            if (CSUM_EN) send_byte(c, 0);
         end
         wait_idle($sformatf("rand%0d", it));
      end
      ready_mode = 0;
      tick();
      compare_mon("rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
